fp_div_wb: RTL and testbench
============================

FP_DIV_WB -- requirements
Module: fp_div_wb

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width.
REQ-002 SHALL have parameter DIV_LAT, default 3, fixed cycles from operand launch into fp_div to its registered result.
REQ-003 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: issue_valid  in  1  an operand pair is launched into fp_div this cycle.
REQ-007 SHALL have ports: issue_ready  out  1  a launch is permitted this cycle.
REQ-008 SHALL have ports: div_out  in  W  fp_div result, plus div_ov, div_un, div_inv, div_dz, div_nx  in  1 each  fp_div exception flags.
REQ-009 SHALL have ports: out_valid  out  1, out_ready  in  1, out_data  out  W, out_flags  out  5  ({NV,DZ,OF,UF,NX}) result handshake.
REQ-010 SHALL have ports: flags_clr  in  1  clear sticky flags; fflags  out  5  sticky accumulated {NV,DZ,OF,UF,NX}.

Function
REQ-011 SHALL track launches with a DIV_LAT-bit valid shift register; bit 0 loads issue_valid&issue_ready, shifting every cycle.
REQ-012 SHALL capture {div_out, flags} into the FIFO exactly in the cycle the shift register's last bit is 1, result never dropped.
REQ-013 SHALL drive issue_ready = (fifo_count + in-flight count) < DEPTH, guaranteeing capture never meets a full FIFO.
REQ-014 SHALL ignore issue_valid when issue_ready=0 (no launch recorded).
REQ-015 SHALL present FIFO head on out_data/out_flags with out_valid=1 when non-empty; pop on out_valid&out_ready.
REQ-016 SHALL support capture and pop in the same cycle with count unchanged, including when full or holding one entry.
REQ-017 SHALL hold out_data/out_flags stable while out_valid=1 and out_ready=0.
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-019 SHALL update fflags on capture as (flags_clr ? 0 : fflags) | captured flags; flags_clr alone zeroes fflags next cycle.
REQ-020 SHALL map flags NV=div_inv, DZ=div_dz, OF=div_ov, UF=div_un, NX=div_nx.
REQ-021 Minimum latency from capture cycle to out_valid SHALL be 1 cycle.

Reset
REQ-022 SHALL, on rst=1 at a clock edge: clear shift register, pointers, count; out_valid=0, out_data=0, out_flags=0, fflags=0, issue_ready=1 next cycle.
REQ-023 SHALL discard in-flight and queued results when rst asserts mid-operation; fp_div results emerging after reset SHALL not be captured.

Configuration
REQ-024 SHALL use macro FP_DIV_WB_FLAGS_EN: defined -> sticky fflags per REQ-019; undefined -> fflags tied 0, flags_clr ignored, no flag register; out_flags unaffected either way.

Structure
REQ-025 SHALL place flag bit indices (NV..NX), flag vector width, and FP constants (FP_NANQ, FP_INFP, FP_ZEROP) in shared package fp_pkg.
REQ-026 SHALL implement storage as sub-module fp_wb_fifo (parameterised width/depth, push/pop/count).

Verification
REQ-027 Single op: issue 1.0/2.0, div_out=0x3F000000 at cycle DIV_LAT, out_ready=1 -> out_valid 1 cycle later, out_data=0x3F000000, out_flags=0, fflags=0.
REQ-028 Back-pressure: out_ready=0, issue every cycle -> issue_ready falls after 4 launches; 4 results queued in order; no overflow; releasing out_ready drains 4 entries.
REQ-029 Sticky flags: result 1.0/0.0 (div_dz=1, out 0x7F800000) then 1.0/3.0 (div_nx=1) -> fflags=5'b01001; flags_clr -> 0; clr coincident with NX capture -> fflags=5'b00001.
REQ-030 Simultaneous push/pop at full FIFO with out_ready=1 -> count stays DEPTH-1/DEPTH correctly, order preserved, issue_ready correct each cycle.
REQ-031 Reset mid-flight: 2 launches then rst 1 cycle -> out_valid=0, fflags=0, no stale results appear afterwards.
REQ-032 FP_DIV_WB_FLAGS_EN undefined: repeat REQ-029 stimulus -> fflags stays 0, out_flags still 5'b01000 then 5'b00001.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg -- shared floating-point constants and exception-flag layout.
// Flag vectors are ordered {NV,DZ,OF,UF,NX}, with NV as the MSB.
// Contents: flag bit indices, flag vector width, IEEE-754 single constants,
// and a helper that packs the fp_div flag wires into that order.
package fp_pkg;

   localparam int FLG_W  = 5;
   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
   localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
   localparam logic [31:0] FP_ZEROP = 32'h0000_0000;

   typedef logic [FLG_W-1:0] fp_flags_t;

   function automatic fp_flags_t pack_flags(input logic inv, input logic dz,
                                            input logic ov, input logic un,
                                            input logic nx);
      fp_flags_t f;
      f         = '0;
      f[FLG_NV] = inv;
      f[FLG_DZ] = dz;
      f[FLG_OF] = ov;
      f[FLG_UF] = un;
      f[FLG_NX] = nx;
      return f;
   endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo -- synchronous FIFO holding fp_div results.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_push, i_data     write strobe and data
//   i_pop              read strobe (ignored when empty)
//   o_data             head entry, zero when empty
//   o_empty, o_count   occupancy status
// A push is accepted when full only if a pop happens in the same cycle.
module fp_wb_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign w_pop   = i_pop && (r_count != '0);
   assign w_push  = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fp_div_wb.sv
// fp_div_wb -- write-back stage for a fixed-latency fp_div unit.
// Tracks launches with a valid shift register, captures the divider result
// and exception flags DIV_LAT cycles after launch into a small FIFO, and
// presents them through a valid/ready handshake. issue_ready reserves FIFO
// room for every in-flight operation, so a capture never finds the FIFO full.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   issue_valid / issue_ready        operand launch handshake
//   div_out, div_ov/un/inv/dz/nx     fp_div result and flags
//   out_valid/out_ready/out_data/out_flags   result handshake, flags {NV,DZ,OF,UF,NX}
//   flags_clr, fflags                sticky flag clear and accumulated flags
// Build option: define FP_DIV_WB_FLAGS_EN to include the sticky fflags
// register; otherwise fflags reads as zero and flags_clr has no effect.
module fp_div_wb
   import fp_pkg::*;
#(
   parameter int W       = 32,
   parameter int DIV_LAT = 3,
   parameter int DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [W-1:0]     div_out,
   input  logic             div_ov,
   input  logic             div_un,
   input  logic             div_inv,
   input  logic             div_dz,
   input  logic             div_nx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [FLG_W-1:0] out_flags,
   input  logic             flags_clr,
   output logic [FLG_W-1:0] fflags
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(DIV_LAT + 1);
   localparam int SW = $clog2(DEPTH + DIV_LAT + 1);

   logic [DIV_LAT-1:0]   r_vld_sr;
   logic                 w_launch;
   logic                 w_capture;
   logic [IW-1:0]        w_inflight;
   logic [AW:0]          w_count;
   logic [SW-1:0]        w_occ;
   logic                 w_empty;
   fp_flags_t            w_flags;
   logic [FLG_W+W-1:0]   w_head;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < DIV_LAT; i++) w_inflight = w_inflight + IW'(r_vld_sr[i]);
   end

   // The op being captured this cycle still counts as in flight here; it
   // moves into w_count at the same edge, so the total stays conservative.
   assign w_occ       = SW'(w_count) + SW'(w_inflight);
   assign issue_ready = (w_occ < SW'(DEPTH));
   assign w_launch    = issue_valid && issue_ready;
   assign w_capture   = r_vld_sr[DIV_LAT-1];
   assign w_flags     = pack_flags(div_inv, div_dz, div_ov, div_un, div_nx);

   always_ff @(posedge clk) begin
      if (rst) r_vld_sr <= '0;
      else     r_vld_sr <= (r_vld_sr << 1) | DIV_LAT'(w_launch);
   end

   fp_wb_fifo #(
      .W     (FLG_W + W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_capture),
      .i_data  ({w_flags, div_out}),
      .i_pop   (out_ready),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign out_valid = !w_empty;
   assign {out_flags, out_data} = w_head;

`ifdef FP_DIV_WB_FLAGS_EN
   logic [FLG_W-1:0] r_fflags;

   // A clear coincident with a capture keeps only the newly captured flags.
   always_ff @(posedge clk) begin
      if (rst)            r_fflags <= '0;
      else if (w_capture) r_fflags <= (flags_clr ? '0 : r_fflags) | w_flags;
      else if (flags_clr) r_fflags <= '0;
   end

   assign fflags = r_fflags;
`else
   logic w_unused_flags_clr;
   assign w_unused_flags_clr = flags_clr;
   assign fflags = '0;
`endif

endmodule

// File: tb/tb_fp_div_wb.sv
module tb_fp_div_wb;
   import fp_pkg::*;

   localparam int W       = 32;
   localparam int DIV_LAT = 3;
   localparam int DEPTH   = 4;
`ifdef FP_DIV_WB_FLAGS_EN
   localparam bit FLAGS_EN = 1'b1;
`else
   localparam bit FLAGS_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         issue_valid;
   logic         issue_ready;
   logic [W-1:0] div_out;
   logic         div_ov, div_un, div_inv, div_dz, div_nx;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [4:0]   out_flags;
   logic         flags_clr;
   logic [4:0]   fflags;

   logic [W-1:0] nxt_res;
   logic [4:0]   nxt_flg;
   logic         smp_ir = 1'b0;
   logic         smp_ov = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [4:0]   f;
      logic [W-1:0] d;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fp_div_wb #(.W(W), .DIV_LAT(DIV_LAT), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .div_out     (div_out),
      .div_ov      (div_ov),
      .div_un      (div_un),
      .div_inv     (div_inv),
      .div_dz      (div_dz),
      .div_nx      (div_nx),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_flags   (out_flags),
      .flags_clr   (flags_clr),
      .fflags      (fflags)
   );

   // Behavioural fp_div: result appears DIV_LAT cycles after launch; idle
   // slots carry junk with all flags set, which must never be captured.
   logic [W+5:0] pipe [DIV_LAT];
   logic [15:0]  junk_cnt = 16'h0;

   always @(posedge clk) begin
      for (int k = DIV_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      if (!rst && issue_valid && smp_ir) pipe[0] <= {1'b1, nxt_flg, nxt_res};
      else                               pipe[0] <= {1'b0, 5'b11111, 16'hDEAD, junk_cnt};
      junk_cnt <= junk_cnt + 16'h1;
   end

   assign div_out = pipe[DIV_LAT-1][W-1:0];
   assign {div_inv, div_dz, div_ov, div_un, div_nx} = pipe[DIV_LAT-1][W+4:W];

   // Scoreboard bookkeeping: entries live from launch edge to pop edge, so
   // the queue size equals FIFO occupancy plus in-flight operations.
   always @(posedge clk) begin
      if (rst) exp_q.delete();
      else begin
         if (smp_ov && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (issue_valid && smp_ir) exp_q.push_back({nxt_flg, nxt_res});
      end
   end

   task automatic sb_monitor();
      forever begin
         @(negedge clk);
         smp_ir = issue_ready;
         smp_ov = out_valid;
         if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: got data=%h flags=%b, expected no output", out_data, out_flags);
            end else if ({out_flags, out_data} !== exp_q[0]) begin
               n_err++;
               $display("FAIL sb_result: got data=%h flags=%b, expected data=%h flags=%b",
                        out_data, out_flags, exp_q[0].d, exp_q[0].f);
            end
         end
      end
   endtask

   task automatic issue(input logic [W-1:0] res, input logic [4:0] flg);
      @(posedge clk); #1;
      issue_valid = 1'b1;
      nxt_res     = res;
      nxt_flg     = flg;
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
      nxt_res = '0; nxt_flg = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
      n_vec++; if (out_data !== '0)      begin n_err++; $display("FAIL rst_out_data: got %h, expected 0", out_data); end
      n_vec++; if (out_flags !== 5'b0)   begin n_err++; $display("FAIL rst_out_flags: got %b, expected 0", out_flags); end
      n_vec++; if (fflags !== 5'b0)      begin n_err++; $display("FAIL rst_fflags: got %b, expected 0", fflags); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_issue_ready: got %b, expected 1", issue_ready); end
   endtask

   task automatic test_single();
      int lat = 0;
      out_ready = 1'b1;
      issue(32'h3F00_0000, 5'b00000);
      for (int c = 1; c <= 20 && lat == 0; c++) begin
         @(negedge clk);
         if (out_valid) lat = c;
      end
      n_vec++; if (lat != DIV_LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d, expected %0d", lat, DIV_LAT + 1); end
      n_vec++; if (out_data !== 32'h3F00_0000) begin n_err++; $display("FAIL single_data: got %h, expected 3f000000", out_data); end
      n_vec++; if (out_flags !== 5'b0) begin n_err++; $display("FAIL single_flags: got %b, expected 0", out_flags); end
      n_vec++; if (fflags !== 5'b0) begin n_err++; $display("FAIL single_fflags: got %b, expected 0", fflags); end
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b, expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int launches = 0;
      int pops = 0;
      logic [W+4:0] hold;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         issue_valid = 1'b1;
         nxt_res     = 32'h4000_0000 + 32'(launches);
         nxt_flg     = 5'(1 << (launches % 5));
         @(negedge clk);
         n_vec++;
         if (issue_ready !== (launches < DEPTH)) begin
            n_err++;
            $display("FAIL bp_issue_ready[%0d]: got %b, expected %b", i, issue_ready, launches < DEPTH);
         end
         if (issue_ready) launches++;
      end
      @(posedge clk); #1 issue_valid = 1'b0;
      n_vec++; if (launches != DEPTH) begin n_err++; $display("FAIL bp_launches: got %0d, expected %0d", launches, DEPTH); end
      repeat (DIV_LAT + 2) @(posedge clk);
      @(negedge clk);
      hold = {out_flags, out_data};
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, expected 1", out_valid); end
      n_vec++; if (out_data !== 32'h4000_0000) begin n_err++; $display("FAIL bp_head: got %h, expected 40000000", out_data); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if ({out_flags, out_data} !== hold) begin
            n_err++;
            $display("FAIL bp_stable[%0d]: got %h, expected %h", i, {out_flags, out_data}, hold);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid) pops++;
      end
      n_vec++; if (pops != DEPTH) begin n_err++; $display("FAIL bp_drain_count: got %0d, expected %0d", pops, DEPTH); end
   endtask

   task automatic test_flags();
      out_ready = 1'b1;
      issue(FP_INFP, 5'b01000);
      issue(32'h3EAA_AAAB, 5'b00001);
      repeat (DIV_LAT + 3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (fflags !== (FLAGS_EN ? 5'b01001 : 5'b0)) begin n_err++; $display("FAIL flags_sticky: got %b, expected %b", fflags, FLAGS_EN ? 5'b01001 : 5'b0); end
      @(posedge clk); #1 flags_clr = 1'b1;
      @(posedge clk); #1 flags_clr = 1'b0;
      @(negedge clk);
      n_vec++; if (fflags !== 5'b0) begin n_err++; $display("FAIL flags_clear: got %b, expected 0", fflags); end
      issue(FP_INFP, 5'b01000);
      repeat (DIV_LAT + 3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (fflags !== (FLAGS_EN ? 5'b01000 : 5'b0)) begin n_err++; $display("FAIL flags_dz: got %b, expected %b", fflags, FLAGS_EN ? 5'b01000 : 5'b0); end
      issue(32'h3EAA_AAAB, 5'b00001);
      repeat (DIV_LAT - 1) @(posedge clk);
      #1 flags_clr = 1'b1;
      @(posedge clk); #1 flags_clr = 1'b0;
      @(negedge clk);
      n_vec++; if (fflags !== (FLAGS_EN ? 5'b00001 : 5'b0)) begin n_err++; $display("FAIL flags_clr_capture: got %b, expected %b", fflags, FLAGS_EN ? 5'b00001 : 5'b0); end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int launches = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         issue_valid = 1'b1;
         out_ready   = (c >= 8);
         nxt_res     = 32'h5000_0000 + 32'(launches);
         nxt_flg     = 5'(launches % 32);
         @(negedge clk);
         n_vec++;
         if (issue_ready !== (exp_q.size() < DEPTH)) begin
            n_err++;
            $display("FAIL b2b_issue_ready[%0d]: got %b, expected %b", c, issue_ready, exp_q.size() < DEPTH);
         end
         if (c == 7) begin
            n_vec++;
            if (out_valid !== 1'b1 || exp_q.size() != DEPTH) begin
               n_err++;
               $display("FAIL b2b_full: got valid=%b occupancy=%0d, expected valid=1 occupancy=%0d", out_valid, exp_q.size(), DEPTH);
            end
         end
         if (issue_ready) launches++;
      end
      @(posedge clk); #1 issue_valid = 1'b0;
      repeat (DIV_LAT + DEPTH + 3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drained: got valid=%b pending=%0d, expected 0/0", out_valid, exp_q.size()); end
      n_vec++; if (launches < 12) begin n_err++; $display("FAIL b2b_throughput: got %0d launches, expected at least 12", launches); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      issue(FP_NANQ, 5'b10000);
      repeat (DIV_LAT + 2) @(posedge clk);
      issue(32'h6000_0001, 5'b00010);
      issue(32'h6000_0002, 5'b00100);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, expected 0", out_valid); end
      n_vec++; if (fflags !== 5'b0) begin n_err++; $display("FAIL midrst_fflags: got %b, expected 0", fflags); end
      n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b, expected 1", issue_ready); end
      @(posedge clk); #1 out_ready = 1'b1;
      for (int c = 0; c < DIV_LAT + 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_stale[%0d]: got valid=1 data=%h, expected valid=0", c, out_data);
         end
      end
   endtask

   initial begin
      rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
      nxt_res = '0; nxt_flg = '0;
      fork
         sb_monitor();
      join_none
      test_reset();
      test_single();
      test_backpressure();
      test_flags();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
